// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: latches a BCD triple and time-multiplexes it onto a 3-digit 7-segment display; define BCD_SEG_LZB_EN for leading-zero blanking
module bcd_seg_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_hundred,
  input  logic [3:0] in_ten,
  input  logic [3:0] in_unit,
  output logic [6:0] seg,
  output logic [2:0] dig_sel,
  output logic       frame_done
);
  localparam int CW = $clog2(SCAN_DIV) + 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [2:0]    hun;
  logic [3:0]    ten, unit, cur;
  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic          wrap_q, dwell_end, cur_bad, blank;
  logic [6:0]    seg_nx;
  logic [2:0]    sel_nx;
  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b0111111;
      4'd1:    dec = 7'b0000110;
      4'd2:    dec = 7'b1011011;
      4'd3:    dec = 7'b1001111;
      4'd4:    dec = 7'b1100110;
      4'd5:    dec = 7'b1101101;
      4'd6:    dec = 7'b1111101;
      4'd7:    dec = 7'b0000111;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
  endfunction
  // select the active digit and build the next display pattern
  always_comb begin
    dwell_end = div_cnt == LAST;
    cur       = idx == 2'd2 ? {1'b0, hun} : idx == 2'd1 ? ten : unit;
    cur_bad   = idx == 2'd2 ? hun > 3'd5 : cur > 4'd9;
`ifdef BCD_SEG_LZB_EN
    blank     = (idx == 2'd2 && hun == 3'd0) || (idx == 2'd1 && hun == 3'd0 && ten == 4'd0);
`else
    blank     = 1'b0;
`endif
    seg_nx    = cur_bad ? 7'b1000000 : blank ? 7'b0000000 : dec(cur);
    sel_nx    = idx == 2'd2 ? 3'b100 : idx == 2'd1 ? 3'b010 : 3'b001;
  end
  // capture, dwell counter, scan index and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hun        <= '0;
      ten        <= '0;
      unit       <= '0;
      div_cnt    <= '0;
      idx        <= '0;
      wrap_q     <= 1'b0;
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (in_valid) begin
        hun  <= in_hundred;
        ten  <= in_ten;
        unit <= in_unit;
      end
      div_cnt    <= dwell_end ? '0 : div_cnt + 1'b1;
      idx        <= dwell_end ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
      wrap_q     <= dwell_end && idx == 2'd2;
      frame_done <= wrap_q;
      seg        <= seg_nx;
      dig_sel    <= sel_nx;
    end
  end
endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream display stage for the binary-to-BCD converter. It captures one hundreds/tens/units BCD triple on a valid strobe and drives a 3-digit common 7-segment display by time-multiplexing the digits. It also flags invalid BCD codes and emits a frame pulse each time a full scan completes.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays selected; legal range 1..65535 (counter width is $clog2(SCAN_DIV)+1).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  capture strobe; the input triple is latched on the rising edge where this is 1.
in_hundred  input  3  hundreds digit, 0..5.
in_ten  input  4  tens digit.
in_unit  input  4  units digit.
seg  output  7  segment pattern {g,f,e,d,c,b,a}, active-high, registered.
dig_sel  output  3  one-hot digit enable {hundred,ten,unit}, active-high, registered.
frame_done  output  1  one-cycle pulse when a scan of the unit, ten and hundred digits completes, registered.

Behaviour:
- Reset (rst_n=0, asynchronous): seg=7'h00, dig_sel=3'b000, frame_done=0, latched digits=0, div_cnt=0, scan index idx=0 (unit).
- Capture: when in_valid=1 at edge E, the three digit registers load at E. seg reflects the new data from edge E+1 onward, if the affected digit is the one selected. in_valid may be asserted every cycle; the last value wins. There is no backpressure.
- Scan: div_cnt counts 0..SCAN_DIV-1 and wraps.
  - When div_cnt==SCAN_DIV-1, idx advances 0(unit) -> 1(ten) -> 2(hundred) -> 0.
  - With SCAN_DIV=1, idx advances every cycle.
- Outputs are registered from (idx, digit regs). At each edge, dig_sel is set to the one-hot of idx (unit=001, ten=010, hundred=100) and seg is set to the decode of the selected digit.
  - First edge after reset release: dig_sel=001.
- Decode (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Invalid code (ten/unit 10..15, hundred 6..7): seg=1000000 (dash).
- frame_done=1 for exactly one cycle, on the edge following the edge where idx wraps 2->0. Period is 3*SCAN_DIV cycles.
- Reset mid-scan: all state clears immediately; scanning restarts at unit with a full SCAN_DIV dwell.
- A capture during a dwell does not disturb div_cnt or idx.

Optional Feature:
BCD_SEG_LZB_EN (leading-zero blanking).
- Defined:
  - Hundred digit shows blank (seg=0000000, dig_sel still asserted) when hundred==0.
  - Ten digit shows blank when hundred==0 and ten==0.
  - Unit digit is never blanked.
  - Blanking uses the latched values; an invalid code is never blanked.
- Undefined: every digit is decoded normally, so zeros are displayed.

Test Plan:
- Reset, then release rst_n; hold for 2 cycles -> seg=0111111, dig_sel=001; after 4 more cycles dig_sel=010 (SCAN_DIV=4).
- in_valid with 1/2/3 -> over one frame, dig_sel=001 gives seg=1001111, 010 gives 1011011, 100 gives 0000110; frame_done pulses once every 12 cycles.
- Capture 0/0/7 -> with BCD_SEG_LZB_EN, hundred and ten show 0000000 and unit shows 0000111; without it, hundred and ten show 0111111.
- Capture hundred=0, ten=4'hC, unit=9 -> ten shows 1000000 (not blanked); unit shows 1101111.
- Back-to-back in_valid (5/5/5 then 2/5/5) while unit is selected -> unit shows 1101101 one edge after each capture; the hundred dwell shows 1011011 (2); div_cnt and idx timing are unchanged.
- Assert rst_n=0 mid-dwell at idx=2 -> seg, dig_sel and frame_done are 0 immediately (asynchronously); after release, dig_sel=001 for exactly 4 cycles.
